// File: rtl/ef_smsdac_dsm.sv
// Second-order error-feedback delta-sigma modulator that turns 16-bit signed samples into 9-bit codes
// for a mismatch-shaping DAC. Optional LFSR dither is enabled with the EF_SMSDAC_DSM_DITHER_EN macro.
module ef_smsdac_dsm #(
    parameter int OSR_LOG2 = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        clr_underrun,
    output logic [7:0]  x,
    output logic        x_c,
    output logic        underrun,
    output logic        sat
);

    // Handshake: s_data is taken on any rising edge where s_valid && s_ready are both high.
    // s_ready depends only on state, never on s_valid.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [OSR_LOG2-1:0] PHASE_MAX = '1;
    localparam logic [OSR_LOG2-1:0] PHASE_ONE = 1;

    state_t              state_q, state_d;
    logic [OSR_LOG2-1:0] phase_q, phase_d;
    logic [15:0]         hold_q, hold_d;
    logic [6:0]          e1_q, e1_d, e2_q, e2_d;
    logic [8:0]          q_q, q_d;
    logic                sat_q, sat_d;
    logic                underrun_q, underrun_d;

    logic                boundary;
    logic                xfer;
    logic [15:0]         u;
    logic signed [18:0]  v;
    logic [15:0]         vclamp;
    logic                v_over;
    logic                dither;

`ifdef EF_SMSDAC_DSM_DITHER_EN
    logic [14:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (state_q == RUN) begin
            lfsr_d = {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= 15'h0001;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign dither = lfsr_q[0];
`else
    assign dither = 1'b0;
`endif

    assign boundary = (state_q == RUN) && (phase_q == PHASE_MAX);
    assign s_ready  = (state_q == IDLE) || boundary;
    assign xfer     = s_valid && s_ready;

    // Offset binary: adding 32768 to a 16-bit two's-complement value only flips the sign bit.
    assign u = hold_q ^ 16'h8000;
    assign v = $signed({3'b000, u}) + $signed({11'b0, e1_q, 1'b0})
             - $signed({12'b0, e2_q}) + $signed({18'b0, dither});

    assign v_over = (v[18] == 1'b0) && (v[17:16] != 2'b00);

    always_comb begin
        vclamp = v[15:0];
        if (v[18]) begin
            vclamp = 16'h0000;
        end else if (v_over) begin
            vclamp = 16'hFFFF;
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        hold_d     = hold_q;
        e1_d       = e1_q;
        e2_d       = e2_q;
        q_d        = q_q;
        sat_d      = sat_q;
        underrun_d = underrun_q;

        if (state_q == IDLE) begin
            phase_d = '0;
            if (xfer) begin
                state_d = RUN;
            end
        end else begin
            phase_d = phase_q + PHASE_ONE;
            q_d     = vclamp[15:7];
            e1_d    = vclamp[6:0];
            e2_d    = e1_q;
            sat_d   = v[18] | v_over;
        end

        if (xfer) begin
            hold_d = s_data;
        end

        // A missing sample at the boundary takes priority over a clear in the same cycle.
        if (boundary && !s_valid) begin
            underrun_d = 1'b1;
        end else if (clr_underrun) begin
            underrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            hold_q     <= 16'h0000;
            e1_q       <= 7'd0;
            e2_q       <= 7'd0;
            q_q        <= 9'h100;
            sat_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            hold_q     <= hold_d;
            e1_q       <= e1_d;
            e2_q       <= e2_d;
            q_q        <= q_d;
            sat_q      <= sat_d;
            underrun_q <= underrun_d;
        end
    end

    assign x        = q_q[8:1];
    assign x_c      = q_q[0];
    assign sat      = sat_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_ef_smsdac_dsm.sv
// Directed bench for ef_smsdac_dsm (dither disabled): an arithmetic reference model checked every
// cycle, plus hand-computed literal expectations for reset, midscale, half-LSB, saturation and underrun.
module tb_ef_smsdac_dsm;

    localparam int OSR_LOG2 = 4;
    localparam int NPH      = 1 << OSR_LOG2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] s_data = 16'h0000;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        clr_underrun = 1'b0;
    logic [7:0]  x;
    logic        x_c;
    logic        underrun;
    logic        sat;

    int n_tests = 0;
    int n_fail  = 0;

    ef_smsdac_dsm #(.OSR_LOG2(OSR_LOG2)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .clr_underrun (clr_underrun),
        .x            (x),
        .x_c          (x_c),
        .underrun     (underrun),
        .sat          (sat)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model (integer arithmetic) ----------------
    bit m_on    = 0;
    bit m_run   = 0;
    int m_phase = 0;
    int m_hold  = 0;
    int m_e1    = 0;
    int m_e2    = 0;
    int m_q     = 256;
    bit m_sat   = 0;
    bit m_under = 0;

    task automatic model_step();
        int v, vc, n_e1, n_e2, n_q, n_phase, n_hold;
        bit ready, xfer, n_run, n_sat, n_under;
        if (rst) begin
            m_on = 1; m_run = 0; m_phase = 0; m_hold = 0;
            m_e1 = 0; m_e2 = 0; m_q = 256; m_sat = 0; m_under = 0;
        end else begin
            ready = !m_run || (m_phase == NPH - 1);
            xfer  = s_valid && ready;
            n_e1 = m_e1; n_e2 = m_e2; n_q = m_q; n_sat = m_sat;
            n_under = m_under; n_hold = m_hold; n_run = m_run;
            if (m_run) begin
                v  = (m_hold + 32768) + 2 * m_e1 - m_e2;
                vc = (v < 0) ? 0 : ((v > 65535) ? 65535 : v);
                n_q   = vc / 128;
                n_e2  = m_e1;
                n_e1  = vc % 128;
                n_sat = (v < 0) || (v > 65535);
                n_phase = (m_phase + 1) % NPH;
            end else begin
                n_phase = 0;
                if (xfer) n_run = 1;
            end
            if (m_run && m_phase == NPH - 1 && !s_valid) n_under = 1;
            else if (clr_underrun) n_under = 0;
            if (xfer) n_hold = int'($signed(s_data));
            m_run = n_run; m_phase = n_phase; m_hold = n_hold; m_e1 = n_e1;
            m_e2 = n_e2; m_q = n_q; m_sat = n_sat; m_under = n_under;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (m_on) begin
            chk("model_q", int'({x, x_c}), m_q);
            chk("model_sat", int'(sat), int'(m_sat));
            chk("model_underrun", int'(underrun), int'(m_under));
            chk("model_s_ready", int'(s_ready), int'(!m_run || (m_phase == NPH - 1)));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; s_valid = 1'b0; clr_underrun = 1'b0; s_data = 16'h0000;
        cyc(n);
        rst = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_x"}, int'(x), 8'h80);
        chk({tag, "_x_c"}, int'(x_c), 0);
        chk({tag, "_sat"}, int'(sat), 0);
        chk({tag, "_underrun"}, int'(underrun), 0);
        chk({tag, "_s_ready"}, int'(s_ready), 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int qs[32];
        int sum;
        bit sat_seen;

        // Reset: three cycles high
        do_reset(3);
        chk_reset_vals("reset");

        // Midscale: q stays at 256 every cycle
        s_data = 16'h0000; s_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            chk("mid_q", int'({x, x_c}), 256);
        end

        // Half-LSB: q in {256,257}, any 16-cycle window sums to 4104 +- 2
        do_reset(2);
        s_data = 16'h0040; s_valid = 1'b1;
        cyc(4);
        for (int i = 0; i < 32; i++) begin
            cyc(1);
            qs[i] = int'({x, x_c});
            chk("hlsb_range", int'(qs[i] == 256 || qs[i] == 257), 1);
        end
        for (int w = 0; w <= 16; w += 4) begin
            sum = 0;
            for (int i = 0; i < 16; i++) sum += qs[w + i];
            chk("hlsb_sum_in_4102_4106", int'(sum >= 4102 && sum <= 4106), 1);
        end

        // Positive full scale: q pinned at 511, sat asserted, no wrap
        do_reset(2);
        s_data = 16'h7FFF; s_valid = 1'b1;
        cyc(3);
        sat_seen = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            chk("satp_q", int'({x, x_c}), 511);
            if (sat) sat_seen = 1;
        end
        chk("satp_sat_seen", int'(sat_seen), 1);

        // Negative full scale: q steady at 0, no sat
        do_reset(2);
        s_data = 16'h8000; s_valid = 1'b1;
        cyc(3);
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            chk("satn_q", int'({x, x_c}), 0);
            chk("satn_sat", int'(sat), 0);
        end

        // Underrun: one sample then s_valid low across the boundary
        do_reset(2);
        s_data = 16'h1234; s_valid = 1'b1;
        cyc(1);
        s_valid = 1'b0;
        cyc(15);
        chk("under_ready_at_ph15", int'(s_ready), 1);
        chk("under_before", int'(underrun), 0);
        cyc(1);
        chk("under_set", int'(underrun), 1);
        chk("under_ready_after", int'(s_ready), 0);
        clr_underrun = 1'b1;
        cyc(1);
        clr_underrun = 1'b0;
        chk("under_cleared", int'(underrun), 0);
        cyc(14);
        clr_underrun = 1'b1;
        cyc(1);
        clr_underrun = 1'b0;
        chk("under_set_wins", int'(underrun), 1);
        cyc(3);

        // Reset mid-RUN at phase 7
        do_reset(2);
        s_data = 16'h4000; s_valid = 1'b1;
        cyc(8);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        s_valid = 1'b0;
        chk_reset_vals("midrst");
        cyc(1);
        chk("midrst_ready_idle", int'(s_ready), 1);
        chk("midrst_q_idle", int'({x, x_c}), 256);
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ef_smsdac_dsm.md
EF_SMSDAC_DSM -- requirements
Module: ef_smsdac_dsm

Interface
REQ-001 SHALL have parameter OSR_LOG2, default 4, log2 of oversampling ratio (hold length 2^OSR_LOG2 cycles per input sample), legal 1..8.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port s_data  input  16  signed two's-complement input sample.
REQ-005 SHALL have port s_valid  input  1  s_data valid.
REQ-006 SHALL have port s_ready  output  1  block accepts s_data this cycle.
REQ-007 SHALL have port clr_underrun  input  1  clears underrun flag.
REQ-008 SHALL have port x  output  8  modulator code bits 8:1; x[6:0] feed the mismatch-shaping encoder x, x[7] drives the 128x element.
REQ-009 SHALL have port x_c  output  1  modulator code bit 0 (half-LSB), feeds encoder x_c.
REQ-010 SHALL have port underrun  output  1  sticky: sample missing at hold-period boundary.
REQ-011 SHALL have port sat  output  1  registered; high when the current output code was clamped.

Function
REQ-012 SHALL implement states IDLE (no sample yet) and RUN; IDLE->RUN on first s_valid&&s_ready; RUN->IDLE only on rst.
REQ-013 SHALL assert s_ready when state==IDLE, or state==RUN and phase==2^OSR_LOG2-1; transfer occurs when s_valid&&s_ready.
REQ-014 SHALL keep phase counter (OSR_LOG2 bits) at 0 in IDLE, increment every RUN cycle, wrap 2^OSR_LOG2-1 -> 0; counter loaded to 0 on IDLE->RUN transfer.
REQ-015 SHALL load hold register with s_data on transfer; at a RUN boundary with s_valid low, hold register keeps prior sample and underrun sets.
REQ-016 SHALL clear underrun on clr_underrun; simultaneous set and clear -> set wins.
REQ-017 SHALL form u = hold + 32768 (16-bit unsigned offset binary).
REQ-018 SHALL compute v = u + 2*e1 - e2 (19-bit signed), clamp to [0,65535], q = vclamp[15:7] (9 bits), e = vclamp[6:0] (0..127); e2<=e1, e1<=e each RUN cycle.
REQ-019 SHALL register {x,x_c} <= q and sat <= (v<0 or v>65535) each RUN cycle; in IDLE outputs hold reset values and e1/e2 stay 0.
REQ-020 SHALL have latency 2 cycles: sample transferred at edge N appears in q registered at edge N+1 (output valid after edge N+1, visible cycle N+2 relative to handshake cycle).
REQ-021 SHALL guarantee no wrap-around: full-scale inputs saturate q at 0 or 511.

Reset
REQ-022 SHALL on rst: state=IDLE, phase=0, hold=0, e1=e2=0, x=8'h80, x_c=0, sat=0, underrun=0, dither LFSR=15'h0001.
REQ-023 SHALL let rst override all other inputs, including mid-RUN; s_ready=1 in the cycle after rst deasserts.

Configuration
REQ-024 SHALL, with EF_SMSDAC_DSM_DITHER_EN defined, include a 15-bit Fibonacci LFSR (x^15+x^14+1), advancing each RUN cycle, whose bit 0 is added to v before clamping.
REQ-025 SHALL, without EF_SMSDAC_DSM_DITHER_EN, contain no LFSR, with dither term 0, bit-exact to REQ-018.

Verification (dither macro undefined)
REQ-026 SHALL verify reset: rst high 3 cycles -> x=8'h80, x_c=0, sat=0, underrun=0, s_ready=1.
REQ-027 SHALL verify midscale: s_data=16'sh0000 continuously -> q=256 ({x,x_c}=9'h100) every RUN cycle, e1=e2=0.
REQ-028 SHALL verify half-LSB: s_data=16'sh0040 (u=32832) -> q in {256,257} only, sum of q over any 16 consecutive RUN cycles = 4104+-2.
REQ-029 SHALL verify saturation: s_data=16'sh7FFF -> q=511, sat pulses, no wrap to 0; s_data=16'sh8000 -> q=0 steady, sat=0.
REQ-030 SHALL verify underrun: OSR_LOG2=4, s_valid low at phase 15 -> underrun=1 next cycle, q unchanged sample; clr_underrun pulse -> underrun=0.
REQ-031 SHALL verify reset mid-RUN: rst at phase 7 -> next cycle IDLE, outputs at reset values, s_ready=1.
